// File: rtl/cpu_muldiv_sequencer.sv
// RV32M sequencer: captures operands, times the shared multiplier and divider,
// resolves divide special cases, and de-duplicates re-presented ops by tag.
module cpu_muldiv_sequencer #(
  parameter int unsigned MUL_LATENCY = 3,
  parameter int unsigned DIV_LATENCY = 17
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_request,
  input  logic        i_tag,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_rs1,
  input  logic [31:0] i_rs2,
  output logic        o_busy,
  output logic        o_ready,
  output logic [31:0] o_result,
  output logic        o_tag,
  output logic        o_mul_signed1,
  output logic        o_mul_signed2,
  output logic [31:0] o_op1,
  output logic [31:0] o_op2,
  input  logic [63:0] i_mul_result,
  output logic        o_div_signed,
  input  logic [31:0] i_div_result,
  input  logic [31:0] i_div_remainder
);

  typedef enum logic [1:0] {
    IDLE,
    MUL_WAIT,
    DIV_WAIT,
    DONE
  } state_t;

  state_t      state, state_n;
  logic [4:0]  count, count_n;
  logic [2:0]  op, op_n;
  logic        tag, tag_n;
  logic [31:0] result_n, op1_n, op2_n;
  logic        otag_n, s1_n, s2_n, ds_n;
  logic        waiting, accept, is_div;
  logic        div_signed, rs2_zero, overflow;
  logic [31:0] mul_sel, div_sel;

  assign waiting = (state == MUL_WAIT) || (state == DIV_WAIT);
  assign accept = (state == IDLE) && i_request && (i_tag != o_tag);
  assign is_div = i_op[2];
  assign div_signed = is_div && !i_op[0];
  assign rs2_zero = (i_rs2 == 32'h0);
  assign overflow = div_signed && (i_rs1 == 32'h8000_0000)
                    && (i_rs2 == 32'hFFFF_FFFF);

  // DONE is excluded so the stage can retire the op in the ready cycle
  assign o_busy = waiting || (i_request && (i_tag != o_tag));
  assign o_ready = (state == DONE);

  assign mul_sel = (op[1:0] == 2'b00) ? i_mul_result[31:0]
                                      : i_mul_result[63:32];
  assign div_sel = op[1] ? i_div_remainder : i_div_result;

  always_comb begin
    state_n  = state;
    count_n  = count;
    op_n     = op;
    tag_n    = tag;
    result_n = o_result;
    otag_n   = o_tag;
    op1_n    = o_op1;
    op2_n    = o_op2;
    s1_n     = o_mul_signed1;
    s2_n     = o_mul_signed2;
    ds_n     = o_div_signed;
    unique case (state)
      IDLE: begin
        if (accept) begin
          op_n  = i_op;
          tag_n = i_tag;
          op1_n = i_rs1;
          op2_n = i_rs2;
          s1_n  = !is_div && (i_op[1:0] != 2'b11);
          s2_n  = !is_div && !i_op[1];
          ds_n  = div_signed;
          unique case (1'b1)
            !is_div: begin
              count_n = 5'(MUL_LATENCY);
              state_n = MUL_WAIT;
            end
            is_div && rs2_zero: begin
              result_n = i_op[1] ? i_rs1 : 32'hFFFF_FFFF;
              otag_n   = i_tag;
              state_n  = DONE;
            end
            is_div && overflow: begin
              result_n = i_op[1] ? 32'h0 : 32'h8000_0000;
              otag_n   = i_tag;
              state_n  = DONE;
            end
            default: begin
              count_n = 5'(DIV_LATENCY);
              state_n = DIV_WAIT;
            end
          endcase
        end
      end
      MUL_WAIT, DIV_WAIT: begin
        count_n = count - 5'd1;
        if (count == 5'd1) begin
          result_n = (state == MUL_WAIT) ? mul_sel : div_sel;
          otag_n   = tag;
          state_n  = DONE;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state         <= IDLE;
      count         <= '0;
      op            <= '0;
      tag           <= 1'b0;
      o_result      <= '0;
      o_tag         <= 1'b0;
      o_op1         <= '0;
      o_op2         <= '0;
      o_mul_signed1 <= 1'b0;
      o_mul_signed2 <= 1'b0;
      o_div_signed  <= 1'b0;
    end else begin
      state         <= state_n;
      count         <= count_n;
      op            <= op_n;
      tag           <= tag_n;
      o_result      <= result_n;
      o_tag         <= otag_n;
      o_op1         <= op1_n;
      o_op2         <= op2_n;
      o_mul_signed1 <= s1_n;
      o_mul_signed2 <= s2_n;
      o_div_signed  <= ds_n;
    end
  end

endmodule
